// File: rtl/otp_pkg.sv
// Shared constants for the OTP generator: state encoding, LFSR tap mask,
// default seed and per-digit reject limit, plus the LFSR step function.
package otp_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [15:0] OTP_TAP_MASK = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
    localparam int unsigned MAX_REJECT   = 63;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? OTP_TAP_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/otp_lfsr.sv
// 16-bit right-shifting Galois LFSR with load and step controls.
// A zero load value is replaced by the default seed so the state never locks up.
module otp_lfsr #(
    parameter logic [15:0] SEED_VAL = otp_pkg::SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);
    import otp_pkg::*;

    logic [15:0] r_q;

    // Reset wins over load, load wins over step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SEED_VAL;
        end else if (load) begin
            r_q <= (load_val == 16'h0000) ? SEED_VAL : load_val;
        end else if (step) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/otp_gen_ctrl.sv
// OTP generator: draws four BCD digits from an LFSR by rejection sampling.
// Define OTP_FREE_RUN_EN to let the LFSR advance while idle.
module otp_gen_ctrl #(
    parameter int unsigned MAX_REJECT   = otp_pkg::MAX_REJECT,
    parameter logic [15:0] SEED_DEFAULT = otp_pkg::SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gen_req,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [15:0] otp_digit,
    output logic        otp_latch,
    output logic        gen_busy,
    output logic        gen_fallback
);
    import otp_pkg::*;

    localparam logic [15:0] LP_MAX_REJ = 16'(MAX_REJECT);

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic [15:0] r_rej_cnt;
    logic [15:0] r_shadow;
    logic [15:0] r_otp;
    logic        r_latch;
    logic        r_fallback;

    logic [15:0] w_lfsr_q;
    logic        w_step;
    logic [3:0]  w_cand;
    logic        w_force;
    logic        w_accept;
    logic [3:0]  w_digit;
    logic [15:0] w_shadow_nxt;

    otp_lfsr #(
        .SEED_VAL (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step     (w_step),
        .load     (seed_load),
        .load_val (seed),
        .q        (w_lfsr_q)
    );

`ifdef OTP_FREE_RUN_EN
    assign w_step = (r_state == ST_COLLECT) || (r_state == ST_IDLE);
`else
    assign w_step = (r_state == ST_COLLECT);
`endif

    assign w_cand   = w_lfsr_q[3:0];
    assign w_force  = (r_rej_cnt == LP_MAX_REJ);
    assign w_accept = (w_cand <= 4'd9) || w_force;
    assign w_digit  = (w_cand >= 4'd10) ? (w_cand - 4'd10) : w_cand;

    // Shadow register with the current candidate placed at the digit index.
    always_comb begin
        w_shadow_nxt = r_shadow;
        case (r_idx)
            2'd0:    w_shadow_nxt[15:12] = w_digit;
            2'd1:    w_shadow_nxt[11:8]  = w_digit;
            2'd2:    w_shadow_nxt[7:4]   = w_digit;
            default: w_shadow_nxt[3:0]   = w_digit;
        endcase
    end

    // Control FSM: collect digits, publish the full OTP in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_rej_cnt  <= 16'd0;
            r_shadow   <= 16'h0000;
            r_otp      <= 16'h0000;
            r_latch    <= 1'b0;
            r_fallback <= 1'b0;
        end else if (seed_load) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_rej_cnt <= 16'd0;
            r_latch   <= 1'b0;
        end else begin
            r_latch <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (gen_req) begin
                        r_state    <= ST_COLLECT;
                        r_idx      <= 2'd0;
                        r_rej_cnt  <= 16'd0;
                        r_shadow   <= 16'h0000;
                        r_fallback <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_shadow  <= w_shadow_nxt;
                        r_rej_cnt <= 16'd0;
                        if (w_force) begin
                            r_fallback <= 1'b1;
                        end
                        if (r_idx == 2'd3) begin
                            r_otp   <= w_shadow_nxt;
                            r_latch <= 1'b1;
                            r_state <= ST_DONE;
                            r_idx   <= 2'd0;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else begin
                        r_rej_cnt <= r_rej_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign otp_digit    = r_otp;
    assign otp_latch    = r_latch;
    assign gen_busy     = (r_state != ST_IDLE);
    assign gen_fallback = r_fallback;

endmodule
